pfpu_regf_gen: RTL and testbench

//  Parametrised PFPU register file: 2^AW x DW triple-port storage, two ALU read ports (A, B) plus a CSR port

---
 rtl/pfpu_regf_gen_pkg.sv | 26 ++
 rtl/pfpu_regf_gen_if.sv | 29 ++
 rtl/pfpu_regf_gen_tpram.sv | 26 ++
 rtl/pfpu_regf_gen.sv | 169 ++++++++++++++++
 tb/tb_pfpu_regf_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pfpu_regf_gen_pkg.sv
// Shared defaults and encodings for the PFPU register file.
// The optional feature is selected by the PFPU_REGF_BYPASS_EN macro (see pfpu_regf_gen.sv).
package pfpu_regf_gen_pkg;

    localparam int PFPU_DW       = 32;
    localparam int PFPU_AW       = 7;
    localparam int PFPU_NOVL     = 2;
    localparam int PFPU_OVL_BASE = 0;   // overlay registers start at address 0
    localparam int PFPU_IFB_REG  = 2;
    localparam int PFPU_SCW      = 8;

    // Sweep state: CLEAR zeroes the RAM after reset, RUN is normal operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Source of a read port's output for the cycle after the address edge.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_OVL  = 2'd2,
        SEL_BYP  = 2'd3
    } sel_t;

endpackage

// File: rtl/pfpu_regf_gen_if.sv
// ALU/CSR access bus of the PFPU register file.
// master = sequencer/ALU/CSR side, slave = register file.
interface pfpu_regf_gen_if #(
    parameter int DW = 32,
    parameter int AW = 7
);
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] r;
    logic          c_en;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_di;
    logic          c_w_en;
    logic [DW-1:0] c_do;

    modport master (
        output a_addr, b_addr, w_en, w_addr, r, c_en, c_addr, c_di, c_w_en,
        input  a, b, c_do
    );

    modport slave (
        input  a_addr, b_addr, w_en, w_addr, r, c_en, c_addr, c_di, c_w_en,
        output a, b, c_do
    );
endinterface

// File: rtl/pfpu_regf_gen_tpram.sv
// Two read-first synchronous read ports plus one write port.
// No reset on the array; the owner masks outputs until it has cleared it.
module pfpu_tpram_p #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [2**AW];

    // Write and read at the same edge; reads see the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata_a <= r_mem[i_raddr_a];
        o_rdata_b <= r_mem[i_raddr_b];
    end

endmodule

// File: rtl/pfpu_regf_gen.sv
// PFPU register file: post-reset clear sweep, overlay registers, stray-write
// detection, IF-branch flag. Define PFPU_REGF_BYPASS_EN to make a same-edge read
// of the address being written return the new data (otherwise read-first).
module pfpu_regf_gen
    import pfpu_regf_gen_pkg::*;
#(
    parameter int DW      = PFPU_DW,
    parameter int AW      = PFPU_AW,
    parameter int NOVL    = PFPU_NOVL,
    parameter int IFB_REG = PFPU_IFB_REG,
    parameter int SCW     = PFPU_SCW
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    pfpu_regf_gen_if.slave     bus,
    output logic               busy,
    output logic               ifb,
    input  logic [NOVL*DW-1:0] ovl,
    output logic               err_stray,
    output logic [SCW-1:0]     stray_cnt,
    input  logic               stray_clr
);

    localparam logic [AW-1:0]  LAST_ADDR = '1;
    localparam logic [AW-1:0]  OVL_LIM   = AW'(NOVL);
    localparam logic [AW-1:0]  IFB_ADDR  = AW'(IFB_REG);
    localparam logic [SCW-1:0] CNT_MAX   = '1;
`ifdef PFPU_REGF_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic          w_run;
    logic [AW-1:0] w_pa_addr, w_wa;
    logic          w_we, w_wr_acc, w_wr_ovl, w_stray;
    logic [DW-1:0] w_wd;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_wa;
    logic [DW-1:0] w_ram_wd, w_ram_a, w_ram_b;
    sel_t          w_a_sel, w_b_sel, r_a_sel, r_b_sel;
    logic [DW-1:0] w_a_ovl, w_b_ovl, r_a_ovl, r_b_ovl, r_byp;
    logic [DW-1:0] w_a, w_b;

    // CSR takes over port A and the write port when c_en is high.
    assign w_pa_addr = bus.c_en ? bus.c_addr : bus.a_addr;
    assign w_we      = bus.c_en ? bus.c_w_en : bus.w_en;
    assign w_wa      = bus.c_en ? bus.c_addr : bus.w_addr;
    assign w_wd      = bus.c_en ? bus.c_di   : bus.r;

    assign w_run    = (r_state == ST_RUN);
    assign w_wr_acc = w_run && w_we;
    assign w_wr_ovl = (w_wa < OVL_LIM);
    assign w_stray  = w_wr_acc && w_wr_ovl;

    // During the sweep the write port belongs to the clear pointer.
    assign w_ram_we = !w_run || (w_wr_acc && !w_wr_ovl);
    assign w_ram_wa = w_run ? w_wa : r_ptr;
    assign w_ram_wd = w_run ? w_wd : '0;

    pfpu_tpram_p #(.DW(DW), .AW(AW)) u_ram (
        .i_clk     (sys_clk),
        .i_we      (w_ram_we),
        .i_waddr   (w_ram_wa),
        .i_wdata   (w_ram_wd),
        .i_raddr_a (w_pa_addr),
        .i_raddr_b (bus.b_addr),
        .o_rdata_a (w_ram_a),
        .o_rdata_b (w_ram_b)
    );

    // State register and clear pointer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) r_ptr <= r_ptr + 1'b1;
        end
    end

    // Leave CLEAR once the last address has been zeroed; RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (r_ptr == LAST_ADDR) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Pick each port's source and the overlay slice it would need.
    always_comb begin
        w_a_ovl = '0;
        w_b_ovl = '0;
        for (int k = 0; k < NOVL; k++) begin
            if (w_pa_addr  == AW'(k)) w_a_ovl = ovl[k*DW +: DW];
            if (bus.b_addr == AW'(k)) w_b_ovl = ovl[k*DW +: DW];
        end
        w_a_sel = SEL_RAM;
        w_b_sel = SEL_RAM;
        if (!w_run)                                              w_a_sel = SEL_ZERO;
        else if (w_pa_addr < OVL_LIM)                            w_a_sel = SEL_OVL;
        else if (BYP_EN && w_ram_we && w_wa == w_pa_addr)        w_a_sel = SEL_BYP;
        if (!w_run)                                              w_b_sel = SEL_ZERO;
        else if (bus.b_addr < OVL_LIM)                           w_b_sel = SEL_OVL;
        else if (BYP_EN && w_ram_we && w_wa == bus.b_addr)       w_b_sel = SEL_BYP;
    end

    // Registered read-side selects and side data; reset selects output zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_a_sel <= SEL_ZERO;
            r_b_sel <= SEL_ZERO;
            r_a_ovl <= '0;
            r_b_ovl <= '0;
            r_byp   <= '0;
        end else begin
            r_a_sel <= w_a_sel;
            r_b_sel <= w_b_sel;
            r_a_ovl <= w_a_ovl;
            r_b_ovl <= w_b_ovl;
            r_byp   <= w_wd;
        end
    end

    // Output muxes.
    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_a_sel)
            SEL_RAM: w_a = w_ram_a;
            SEL_OVL: w_a = r_a_ovl;
            SEL_BYP: w_a = r_byp;
            default: w_a = '0;
        endcase
        case (r_b_sel)
            SEL_RAM: w_b = w_ram_b;
            SEL_OVL: w_b = r_b_ovl;
            SEL_BYP: w_b = r_byp;
            default: w_b = '0;
        endcase
    end

    assign bus.a    = w_a;
    assign bus.b    = w_b;
    assign bus.c_do = w_a;

    // IF-branch flag, stray pulse and saturating stray counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ifb       <= 1'b0;
            err_stray <= 1'b0;
            stray_cnt <= '0;
        end else begin
            if (w_wr_acc && w_wa == IFB_ADDR) ifb <= (w_wd != '0);
            err_stray <= w_stray;
            if (stray_clr)                           stray_cnt <= '0;
            else if (w_stray && stray_cnt != CNT_MAX) stray_cnt <= stray_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pfpu_regf_gen.sv
// Randomised + directed bench for pfpu_regf_gen against an array-based model.
module tb_pfpu_regf_gen;

    localparam int DW = 32, AW = 7, DEPTH = 128, NOVL = 2, IFB = 2, CMAX = 255;
`ifdef PFPU_REGF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             busy, ifb, err_stray, stray_clr;
    logic [NOVL*DW-1:0] ovl;
    logic [7:0]       stray_cnt;

    always #5 sys_clk = ~sys_clk;

    pfpu_regf_gen_if #(.DW(DW), .AW(AW)) bus ();

    pfpu_regf_gen dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bus       (bus),
        .busy      (busy),
        .ifb       (ifb),
        .ovl       (ovl),
        .err_stray (err_stray),
        .stray_cnt (stray_cnt),
        .stray_clr (stray_clr)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: cleared-cycle count, stored words, flag, counter, expected outputs.
    logic [31:0] m_mem [DEPTH];
    int          m_clr, m_cnt;
    bit          m_ifb, m_err;
    logic [31:0] m_a, m_b;

    function automatic logic [31:0] mread(int addr, bit we, int wa, logic [31:0] wd);
        if (addr < NOVL) return ovl[addr*32 +: 32];
        if (BYP && we && wa == addr) return wd;
        return m_mem[addr];
    endfunction

    task automatic idle();
        bus.a_addr = '0; bus.b_addr = '0; bus.w_en = 1'b0; bus.w_addr = '0; bus.r = '0;
        bus.c_en = 1'b0; bus.c_addr = '0; bus.c_di = '0; bus.c_w_en = 1'b0; stray_clr = 1'b0;
    endtask

    // One clock: predict from pre-edge inputs, then compare every output.
    task automatic tick();
        int pa, wa;
        bit we;
        logic [31:0] wd;
        pa = bus.c_en ? int'(bus.c_addr) : int'(bus.a_addr);
        we = bus.c_en ? bus.c_w_en : bus.w_en;
        wa = bus.c_en ? int'(bus.c_addr) : int'(bus.w_addr);
        wd = bus.c_en ? bus.c_di : bus.r;
        if (m_clr < DEPTH) begin
            m_a = 0; m_b = 0; m_err = 0; m_clr++;
        end else begin
            m_a   = mread(pa, we, wa, wd);
            m_b   = mread(int'(bus.b_addr), we, wa, wd);
            m_err = we && wa < NOVL;
            if (we && wa >= NOVL) m_mem[wa] = wd;
            if (we && wa == IFB) m_ifb = (wd != 0);
        end
        if (stray_clr) m_cnt = 0;
        else if (m_err && m_cnt < CMAX) m_cnt++;
        @(posedge sys_clk); #1;
        chk("a", bus.a, m_a);
        chk("b", bus.b, m_b);
        chk("c_do", bus.c_do, m_a);
        chk("busy", 32'(busy), 32'(m_clr < DEPTH));
        chk("ifb", 32'(ifb), 32'(m_ifb));
        chk("err_stray", 32'(err_stray), 32'(m_err));
        chk("stray_cnt", 32'(stray_cnt), 32'(m_cnt));
    endtask

    // Assert reset away from the edge, check reset values, release.
    task automatic do_reset();
        sys_rst = 1'b1;
        #2;
        m_clr = 0; m_cnt = 0; m_ifb = 0; m_err = 0; m_a = 0; m_b = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_a", bus.a, 32'd0);
        chk("rst_b", bus.b, 32'd0);
        chk("rst_cnt", 32'(stray_cnt), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 3);
            1:       return 20 + $urandom_range(0, 3);
            default: return $urandom_range(0, DEPTH - 1);
        endcase
    endfunction

    initial begin
        int n;
        idle();
        ovl = {32'h0000BBBB, 32'h0000AAAA};
        #1;
        do_reset();

        // Abort the sweep halfway; it must restart from 0.
        for (int i = 0; i < 50; i++) tick();
        #2;
        do_reset();

        // Sweep length, reads and dropped writes while busy.
        bus.a_addr = 7'd5; bus.b_addr = 7'd127;
        bus.w_en = 1'b1; bus.w_addr = 7'd10; bus.r = 32'hDEAD0001;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("busy_len", 32'(n), 32'd128);
        idle();

        // Write then read both ports.
        bus.a_addr = 7'd10; bus.b_addr = 7'd10;
        tick();
        chk("dropped", bus.a, 32'd0);
        bus.w_en = 1'b1; bus.w_addr = 7'd10; bus.r = 32'h3F800000;
        bus.a_addr = 7'd0; bus.b_addr = 7'd1;
        tick();
        idle();
        bus.a_addr = 7'd10; bus.b_addr = 7'd10;
        tick();
        chk("rd10_a", bus.a, 32'h3F800000);
        chk("rd10_b", bus.b, 32'h3F800000);

        // Same-edge read/write of address 20.
        bus.w_en = 1'b1; bus.w_addr = 7'd20; bus.r = 32'h12345678;
        bus.a_addr = 7'd20; bus.b_addr = 7'd20;
        tick();
        chk("same_edge", bus.a, BYP ? 32'h12345678 : 32'd0);
        idle();
        bus.a_addr = 7'd20;
        tick();
        chk("after_wr20", bus.a, 32'h12345678);

        // Overlay reads and a stray write.
        bus.a_addr = 7'd0; bus.b_addr = 7'd1;
        tick();
        chk("ovl0", bus.a, 32'h0000AAAA);
        chk("ovl1", bus.b, 32'h0000BBBB);
        bus.w_en = 1'b1; bus.w_addr = 7'd1; bus.r = 32'h55;
        bus.a_addr = 7'd1;
        tick();
        chk("stray_pulse", 32'(err_stray), 32'd1);
        chk("stray_one", 32'(stray_cnt), 32'd1);
        chk("ovl1_kept", bus.a, 32'h0000BBBB);
        idle();
        tick();
        chk("stray_end", 32'(err_stray), 32'd0);

        // IF-branch flag via ALU and CSR; ALU write ignored under c_en.
        bus.w_en = 1'b1; bus.w_addr = 7'(IFB); bus.r = 32'd5;
        tick();
        chk("ifb_set", 32'(ifb), 32'd1);
        bus.r = 32'd0;
        tick();
        chk("ifb_clr", 32'(ifb), 32'd0);
        bus.c_en = 1'b1; bus.c_w_en = 1'b1; bus.c_addr = 7'(IFB); bus.c_di = 32'd7;
        bus.w_addr = 7'd30; bus.r = 32'd99;
        tick();
        chk("ifb_csr", 32'(ifb), 32'd1);
        idle();
        bus.a_addr = 7'd30; bus.b_addr = 7'(IFB);
        tick();
        chk("alu_blocked", bus.a, 32'd0);
        chk("csr_stored", bus.b, 32'd7);

        // Saturation, then clear against a concurrent stray write.
        idle();
        bus.w_en = 1'b1; bus.w_addr = 7'd0;
        for (int i = 0; i < 300; i++) begin
            bus.r = $urandom;
            tick();
        end
        chk("sat", 32'(stray_cnt), 32'd255);
        stray_clr = 1'b1;
        tick();
        chk("clr_wins", 32'(stray_cnt), 32'd0);
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.a_addr = 7'(pick_addr());
            bus.b_addr = ($urandom_range(0, 3) == 0) ? bus.a_addr : 7'(pick_addr());
            bus.w_en   = 1'($urandom_range(0, 1));
            bus.w_addr = ($urandom_range(0, 2) == 0) ? bus.a_addr : 7'(pick_addr());
            bus.r      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            bus.c_en   = ($urandom_range(0, 3) == 0);
            bus.c_w_en = 1'($urandom_range(0, 1));
            bus.c_addr = 7'(pick_addr());
            bus.c_di   = $urandom;
            stray_clr  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) ovl = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
